mem_port_arbiter: RTL

//  Shares one single-ported memory2 array between instruction fetch (IF, read-only) and data access (DM, read/write).

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_wait_timer.sv | 34 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM state encoding and requester ids.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arbState_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/arb_wait_timer.sv
// Loadable down-counter holding one fixed memory access latency; done is high in the
// cycle LAT cycles after the load cycle.
module arb_wait_timer #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [CW-1:0] cnt;
    logic          armed;

    // The load cycle counts as the first latency cycle, so LAT-1 is stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= CW'(LAT - 1);
            armed <= 1'b1;
        end else if (done) begin
            armed <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = armed && (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, DM first with
// an IF anti-starvation override. Optional stall counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_dm_stall
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] starveMax = SW'(STARVE_LIMIT);

    arbState_t     state;
    logic [SW-1:0] starveCnt;
    logic          dmWeQ;
    logic          arbOpen;
    logic          dmWins;
    logic          ifWins;
    logic          issue;
    logic          winner;
    logic          latDone;

    // Gated by Reset so nothing issues while reset is held.
    assign arbOpen = (state == IDLE) && !Reset;
    assign dmWins  = arbOpen && dm_req && (!if_req || (starveCnt < starveMax));
    assign ifWins  = arbOpen && if_req && !dmWins;
    assign issue   = dmWins || ifWins;
    assign winner  = dmWins ? REQ_DM : REQ_IF;

    arb_wait_timer #(
        .LAT(MEM_LAT)
    ) uTimer (
        .clk (clk),
        .rst (Reset),
        .load(issue),
        .done(latDone)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            dmWeQ     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dmWins) begin
                        state <= BUSY_DM;
                        dmWeQ <= dm_we;
                        if (if_req && (starveCnt != starveMax)) begin
                            starveCnt <= starveCnt + SW'(1);
                        end
                    end else if (ifWins) begin
                        state     <= BUSY_IF;
                        starveCnt <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (latDone) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        if_gnt    = ifWins;
        dm_gnt    = dmWins;
        mem_en    = issue;
        mem_we    = dmWins && dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_addr = (winner == REQ_DM) ? dm_addr : if_addr;
        end
        if (dmWins) begin
            mem_wdata = dm_wdata;
        end
        if_valid = (state == BUSY_IF) && latDone;
        dm_valid = (state == BUSY_DM) && latDone;
        if_rdata = if_valid ? mem_rdata : '0;
        dm_rdata = (dm_valid && !dmWeQ) ? mem_rdata : '0;
    end

    assign stall_if  = if_req && !if_valid;
    assign stall_mem = dm_req && !dm_valid;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perfIf;
    logic [31:0] perfDm;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            perfIf <= '0;
            perfDm <= '0;
        end else begin
            if (stall_if && (perfIf != '1)) begin
                perfIf <= perfIf + 32'd1;
            end
            if (stall_mem && (perfDm != '1)) begin
                perfDm <= perfDm + 32'd1;
            end
        end
    end

    assign perf_if_stall = perfIf;
    assign perf_dm_stall = perfDm;
`else
    assign perf_if_stall = '0;
    assign perf_dm_stall = '0;
`endif

endmodule
